// File: rtl/hk_spi_bridge.sv
// hk_spi_bridge: carries register accesses from an SPI slave (SCK domain)
// into the wb_clk_i domain as a valid/ready register-file request, and
// returns read data to the SPI slave on spi_idata.
//
// Optional feature macro: HK_SPI_BRIDGE_TIMEOUT_EN
//   defined   -> an 8-bit read-response timeout; on expiry spi_idata=8'hFF
//                and the sticky timeout flag sets.
//   undefined -> a read waits for rsp_valid indefinitely; timeout is tied 0.
//
// Ports
//   wb_clk_i, wb_rstn_i    : clock, asynchronous active-low reset
//   spi_wrstb, spi_rdstb   : write/read strobes from the SPI slave (async)
//   spi_addr, spi_wdata    : address/data, quasi-static while a strobe pends
//   spi_idata              : readback byte returned to the SPI slave
//   req_valid/we/addr/wdata: register-file request, accepted with req_ready
//   req_ready              : register-file accept
//   rsp_valid, rsp_rdata   : single-cycle read response
//   overrun                : sticky, a strobe was dropped
//   timeout                : sticky, a read response timed out
module hk_spi_bridge (
  input  logic       wb_clk_i,
  input  logic       wb_rstn_i,
  input  logic       spi_wrstb,
  input  logic       spi_rdstb,
  input  logic [7:0] spi_addr,
  input  logic [7:0] spi_wdata,
  output logic [7:0] spi_idata,
  output logic       req_valid,
  output logic       req_we,
  output logic [7:0] req_addr,
  output logic [7:0] req_wdata,
  input  logic       req_ready,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_rdata,
  output logic       overrun,
  output logic       timeout
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WREQ  = 2'd1,
    RREQ  = 2'd2,
    RWAIT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;

  logic [2:0]      wr_sync;
  logic [2:0]      rd_sync;
  logic            wr_evt;
  logic            rd_evt;

  logic            wr_pend;
  logic            rd_pend;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [AW-1:0]   rd_addr;

  logic            wr_clr;
  logic            rd_clr;
  logic            wr_ovr;
  logic            rd_ovr;

  logic [DW-1:0]   idata_n;
  logic            req_valid_n;
  logic            req_we_n;
  logic [AW-1:0]   req_addr_n;
  logic [DW-1:0]   req_wdata_n;

`ifdef HK_SPI_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = 8;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
`endif

  // Two-flop synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wr_sync <= '0;
      rd_sync <= '0;
    end else begin
      wr_sync <= {wr_sync[1:0], spi_wrstb};
      rd_sync <= {rd_sync[1:0], spi_rdstb};
    end
  end

  assign wr_evt = wr_sync[1] & ~wr_sync[2];
  assign rd_evt = rd_sync[1] & ~rd_sync[2];

  // An event is dropped only if its pending slot is occupied and not being
  // released by a handshake in this same cycle.
  assign wr_ovr = wr_evt & wr_pend & ~wr_clr;
  assign rd_ovr = rd_evt & rd_pend & ~rd_clr;

  // Pending flags and captured address/data.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_addr <= '0;
    end else begin
      if (wr_evt && (!wr_pend || wr_clr)) begin
        wr_pend <= 1'b1;
        wr_addr <= spi_addr;
        wr_data <= spi_wdata;
      end else if (wr_clr) begin
        wr_pend <= 1'b0;
      end
      if (rd_evt && (!rd_pend || rd_clr)) begin
        rd_pend <= 1'b1;
        rd_addr <= spi_addr;
      end else if (rd_clr) begin
        rd_pend <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_n     = state;
    wr_clr      = 1'b0;
    rd_clr      = 1'b0;
    idata_n     = spi_idata;
    req_valid_n = 1'b0;
    req_we_n    = 1'b0;
    req_addr_n  = '0;
    req_wdata_n = '0;
`ifdef HK_SPI_BRIDGE_TIMEOUT_EN
    to_hit      = 1'b0;
`endif

    case (state)
      IDLE: begin
        // Write wins when both are pending.
        if (wr_pend) begin
          state_n = WREQ;
        end else if (rd_pend) begin
          state_n = RREQ;
        end
      end
      WREQ: begin
        if (req_ready) begin
          wr_clr  = 1'b1;
          state_n = IDLE;
        end
      end
      RREQ: begin
        if (req_ready) begin
          rd_clr  = 1'b1;
          state_n = RWAIT;
        end
      end
      RWAIT: begin
        if (rsp_valid) begin
          idata_n = rsp_rdata;
          state_n = IDLE;
        end
`ifdef HK_SPI_BRIDGE_TIMEOUT_EN
        else if (to_cnt == {TO_W{1'b1}}) begin
          idata_n = 8'hFF;
          to_hit  = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Request fields follow the state being entered so they are registered
    // alongside it; captures cannot change while their flag is pending.
    case (state_n)
      WREQ: begin
        req_valid_n = 1'b1;
        req_we_n    = 1'b1;
        req_addr_n  = wr_addr;
        req_wdata_n = wr_data;
      end
      RREQ: begin
        req_valid_n = 1'b1;
        req_addr_n  = rd_addr;
      end
      default: begin
        req_valid_n = 1'b0;
      end
    endcase
  end

  // Registered outputs; overrun is sticky until reset.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      spi_idata <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      req_valid <= req_valid_n;
      req_we    <= req_we_n;
      req_addr  <= req_addr_n;
      req_wdata <= req_wdata_n;
      spi_idata <= idata_n;
      overrun   <= overrun | wr_ovr | rd_ovr;
    end
  end

`ifdef HK_SPI_BRIDGE_TIMEOUT_EN
  // Response-wait counter; held at zero outside RWAIT so it starts from zero
  // on every entry.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state != RWAIT) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      timeout <= timeout | to_hit;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
